vdcorput_fsm_32bit: RTL

- Sequential van der Corput radical-inverse generator; computes vdc(k, b) for small prime bases as a Q16.16 fraction in [0,1).
- Sits directly upstream of the Sphere3Hopf FSM and supplies the per-dimension low-discrepancy coordinates it consumes.
- Processes one base-b digit of k per clock and uses the same start/ready/done handshake as the Sphere3Hopf FSM.

---
 rtl/vdcorput_fsm_32bit.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/vdcorput_fsm_32bit.sv
// Van der Corput radical-inverse generator: vdc(k, b) for b in {2,3,5,7} as Q16.16 in [0,1).
// Build option: define VDC_ROUND_EN for round-half-up with saturation instead of truncation.
module vdcorput_fsm_32bit #(
  parameter int OUT_FRAC_BITS = 16,
  parameter int MAX_DIGITS    = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] k_in,
  input  logic [1:0]  base_sel,
  output logic [31:0] result,
  output logic        done,
  output logic        ready
);

  // Handshake: a job is accepted on a rising edge where start=1 and ready=1.
  // ready drops on acceptance. done pulses for one cycle with result valid from
  // that cycle on. ready returns one cycle after done. A start seen while
  // ready=0 is dropped.

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] k_reg;
  logic [2:0]  b_reg;
  logic [32:0] s_reg;
  logic [31:0] acc;
  logic [5:0]  cnt;

  logic [31:0] k_quot;
  logic [2:0]  k_rem;
  logic [32:0] s_next;
  logic [31:0] prod;
  logic [31:0] acc_next;
  logic        calc_stop;
  logic [2:0]  base_val;

  always_comb begin
    case (base_sel)
      2'd0:    base_val = 3'd2;
      2'd1:    base_val = 3'd3;
      2'd2:    base_val = 3'd5;
      default: base_val = 3'd7;
    endcase
  end

  // One base-b digit per cycle; all divisors are constants selected by b_reg.
  always_comb begin
    k_quot = k_reg;
    k_rem  = 3'd0;
    s_next = s_reg;
    case (b_reg)
      3'd3: begin
        k_quot = k_reg / 32'd3;
        k_rem  = 3'(k_reg % 32'd3);
        s_next = s_reg / 33'd3;
      end
      3'd5: begin
        k_quot = k_reg / 32'd5;
        k_rem  = 3'(k_reg % 32'd5);
        s_next = s_reg / 33'd5;
      end
      3'd7: begin
        k_quot = k_reg / 32'd7;
        k_rem  = 3'(k_reg % 32'd7);
        s_next = s_reg / 33'd7;
      end
      default: begin
        k_quot = k_reg >> 1;
        k_rem  = {2'b00, k_reg[0]};
        s_next = s_reg >> 1;
      end
    endcase
  end

  // rem*S' <= (b-1)*floor(2^32/b) < 2^32, and the running sum stays below 2^32,
  // so a 32-bit product and accumulator are exact.
  always_comb begin
    prod      = s_next[31:0] * {29'd0, k_rem};
    acc_next  = acc + prod;
    calc_stop = (k_reg == 32'd0) || (s_reg == 33'd0) || (cnt == 6'(MAX_DIGITS));
  end

`ifdef VDC_ROUND_EN
  localparam logic [31:0] HALF_LSB = 32'd1 << (OUT_FRAC_BITS - 1);
  localparam logic [31:0] SAT_MAX  = (32'd1 << OUT_FRAC_BITS) - 32'd1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      k_reg  <= 32'd0;
      b_reg  <= 3'd0;
      s_reg  <= 33'd0;
      acc    <= 32'd0;
      cnt    <= 6'd0;
      result <= 32'd0;
      done   <= 1'b0;
      ready  <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          done  <= 1'b0;
          ready <= 1'b1;
          // ready is still low in the cycle right after done, so no accept then.
          if (ready && start) begin
            k_reg <= k_in;
            b_reg <= base_val;
            s_reg <= 33'h1_0000_0000;
            acc   <= 32'd0;
            cnt   <= 6'd0;
            ready <= 1'b0;
            state <= ST_CALC;
          end
        end
        ST_CALC: begin
          if (calc_stop) begin
            state <= ST_DONE;
          end else begin
            k_reg <= k_quot;
            s_reg <= s_next;
            acc   <= acc_next;
            cnt   <= cnt + 6'd1;
          end
        end
        ST_DONE: begin
`ifdef VDC_ROUND_EN
          result <= (acc > ~HALF_LSB) ? SAT_MAX : ((acc + HALF_LSB) >> OUT_FRAC_BITS);
`else
          result <= acc >> OUT_FRAC_BITS;
`endif
          done  <= 1'b1;
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
